// File: rtl/pe_b_pack_buffer.sv
// Packs a stream of operand elements into multi-element words for the PE array.
// An accumulator feeds an output holding register, so the consumer can stall without losing data.
module pe_b_pack_buffer #(
    parameter int ELEM_W = 16,
    parameter int N_ELEM = 4,
    parameter int CNT_W  = $clog2(N_ELEM + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [ELEM_W-1:0]        in_data,
    input  logic                     in_last,
    input  logic                     clear,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ELEM_W*N_ELEM-1:0] out_data,
    output logic [CNT_W-1:0]         out_count,
    output logic [CNT_W-1:0]         acc_count
);

    localparam int WORD_W = ELEM_W * N_ELEM;

    typedef enum logic {
        ACC_FILL,
        ACC_FULL
    } acc_state_t;

    acc_state_t        state_q;
    acc_state_t        state_d;
    logic [WORD_W-1:0] acc_data_q;
    logic [WORD_W-1:0] acc_data_d;
    logic [CNT_W-1:0]  acc_cnt_q;
    logic [CNT_W-1:0]  acc_cnt_d;
    logic [WORD_W-1:0] out_data_q;
    logic [WORD_W-1:0] out_data_d;
    logic [CNT_W-1:0]  out_count_q;
    logic [CNT_W-1:0]  out_count_d;
    logic              out_valid_q;
    logic              out_valid_d;

    logic [WORD_W-1:0] packed_word;
    logic [CNT_W-1:0]  cnt_inc;
    logic              acc_full;
    logic              accept;
    logic              complete;
    logic              slot_free;
    logic              xfer_new;
    logic              xfer_held;

    assign acc_full  = (state_q == ACC_FULL);
    assign in_ready  = !acc_full && !clear;
    assign accept    = in_valid && in_ready;
    assign cnt_inc   = acc_cnt_q + CNT_W'(1);
    assign complete  = accept && ((cnt_inc == CNT_W'(N_ELEM)) || in_last);
    assign slot_free = !out_valid_q || out_ready;
    assign xfer_new  = complete && slot_free;
    // clear wins over a held word: that word is dropped
    assign xfer_held = acc_full && slot_free && !clear;

    // Newest element in the low lane; a fresh word ignores leftover acc_data
    always_comb begin
        packed_word = {{(WORD_W - ELEM_W){1'b0}}, in_data};
        if (acc_cnt_q != '0) begin
            packed_word = {acc_data_q[WORD_W-ELEM_W-1:0], in_data};
        end
    end

    always_comb begin
        state_d    = state_q;
        acc_data_d = acc_data_q;
        acc_cnt_d  = acc_cnt_q;
        if (clear || xfer_held) begin
            state_d    = ACC_FILL;
            acc_data_d = '0;
            acc_cnt_d  = '0;
        end else if (accept) begin
            if (xfer_new) begin
                acc_data_d = '0;
                acc_cnt_d  = '0;
            end else begin
                acc_data_d = packed_word;
                acc_cnt_d  = cnt_inc;
                if (complete) begin
                    state_d = ACC_FULL;
                end
            end
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_count_d = out_count_q;
        if (xfer_new) begin
            out_valid_d = 1'b1;
            out_data_d  = packed_word;
            out_count_d = cnt_inc;
        end else if (xfer_held) begin
            out_valid_d = 1'b1;
            out_data_d  = acc_data_q;
            out_count_d = acc_cnt_q;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ACC_FILL;
            acc_data_q  <= '0;
            acc_cnt_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_count_q <= '0;
        end else begin
            state_q     <= state_d;
            acc_data_q  <= acc_data_d;
            acc_cnt_q   <= acc_cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_count_q <= out_count_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_count = out_count_q;
    assign acc_count = acc_cnt_q;

endmodule

// File: tb/tb_pe_b_pack_buffer.sv
// Bench for pe_b_pack_buffer: vector table plus scoreboard of expected words,
// with hand sequences for backpressure, clear and mid-word reset.
module tb_pe_b_pack_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        in_last;
    logic        clear;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic [2:0]  out_count;
    logic [2:0]  acc_count;

    pe_b_pack_buffer #(.ELEM_W(16), .N_ELEM(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .clear(clear),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_count(out_count),
        .acc_count(acc_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] d;
        logic        last;
        logic        push;
        logic [63:0] exp_d;
        logic [2:0]  exp_c;
    } vec_t;

    typedef struct {
        logic [63:0] d;
        logic [2:0]  c;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   stalls = 0;
    vec_t vecs[14];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    // Pops happen at the edge after a negedge where valid && ready
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_word: got %h want none", out_data);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("word_data", out_data, e.d);
                chk("word_count", 64'(out_count), 64'(e.c));
            end
        end
    end

    // Drive one element from posedge+1; returns at posedge+1 after acceptance
    task automatic send(input logic [15:0] d, input logic last);
        logic acc;
        acc = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        for (int w = 0; w < 50 && !acc; w++) begin
            @(negedge clk);
            if (in_ready) acc = 1'b1;
            else stalls++;
            @(posedge clk);
            #1;
        end
        if (!acc) begin
            total++;
            bad++;
            $display("FAIL send_timeout: got 0 want 1");
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0]  = '{16'h0001, 0, 0, 64'h0, 3'd0};
        vecs[1]  = '{16'h0002, 0, 0, 64'h0, 3'd0};
        vecs[2]  = '{16'h0003, 0, 0, 64'h0, 3'd0};
        vecs[3]  = '{16'h0004, 0, 1, 64'h0001_0002_0003_0004, 3'd4};
        vecs[4]  = '{16'h0011, 0, 0, 64'h0, 3'd0};
        vecs[5]  = '{16'h0012, 0, 0, 64'h0, 3'd0};
        vecs[6]  = '{16'h0013, 0, 0, 64'h0, 3'd0};
        vecs[7]  = '{16'h0014, 0, 1, 64'h0011_0012_0013_0014, 3'd4};
        vecs[8]  = '{16'h0015, 0, 0, 64'h0, 3'd0};
        vecs[9]  = '{16'h0016, 0, 0, 64'h0, 3'd0};
        vecs[10] = '{16'h0017, 0, 0, 64'h0, 3'd0};
        vecs[11] = '{16'h0018, 0, 1, 64'h0015_0016_0017_0018, 3'd4};
        vecs[12] = '{16'h00AA, 0, 0, 64'h0, 3'd0};
        vecs[13] = '{16'h00BB, 1, 1, 64'h0000_0000_00AA_00BB, 3'd2};

        rst = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        in_last = 1'b0;
        clear = 1'b0;
        out_ready = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_acc_count", 64'(acc_count), 64'd0);
        chk("rst_out_data", out_data, 64'd0);
        cycle();

        for (int i = 0; i < 14; i++) begin
            if (vecs[i].push) q.push_back('{vecs[i].exp_d, vecs[i].exp_c});
            send(vecs[i].d, vecs[i].last);
            if (vecs[i].push) begin
                chk("latency_out_valid", 64'(out_valid), 64'd1);
                chk("acc_count_after_word", 64'(acc_count), 64'd0);
            end
        end
        chk("stream_no_stall", 64'(stalls), 64'd0);

        // Word after an in_last word starts empty
        q.push_back('{64'h000C_000D_000E_000F, 3'd4});
        send(16'h000C, 0);
        send(16'h000D, 0);
        send(16'h000E, 0);
        send(16'h000F, 0);

        // Backpressure: second word held in the accumulator
        cycle();
        out_ready = 1'b0;
        q.push_back('{64'h0021_0022_0023_0024, 3'd4});
        q.push_back('{64'h0025_0026_0027_0028, 3'd4});
        for (int i = 0; i < 8; i++) send(16'h0021 + 16'(i), 0);
        @(negedge clk);
        chk("full_in_ready", 64'(in_ready), 64'd0);
        chk("full_acc_count", 64'(acc_count), 64'd4);
        chk("held_out_valid", 64'(out_valid), 64'd1);
        chk("held_data", out_data, 64'h0021_0022_0023_0024);
        cycle();
        cycle();
        @(negedge clk);
        chk("held_data_stable", out_data, 64'h0021_0022_0023_0024);
        chk("held_count_stable", 64'(out_count), 64'd4);
        chk("still_full_in_ready", 64'(in_ready), 64'd0);
        cycle();
        out_ready = 1'b1;
        cycle();
        @(negedge clk);
        chk("second_out_valid", 64'(out_valid), 64'd1);
        chk("second_data", out_data, 64'h0025_0026_0027_0028);
        chk("ready_returns", 64'(in_ready), 64'd1);
        chk("acc_empty_after_xfer", 64'(acc_count), 64'd0);
        cycle();

        // clear discards a partial word and blocks acceptance
        send(16'h0031, 0);
        send(16'h0032, 0);
        send(16'h0033, 0);
        in_valid = 1'b1;
        in_data = 16'h0099;
        clear = 1'b1;
        @(negedge clk);
        chk("clear_in_ready", 64'(in_ready), 64'd0);
        cycle();
        clear = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("clear_acc_count", 64'(acc_count), 64'd0);
        chk("clear_no_output", 64'(out_valid), 64'd0);
        cycle();
        q.push_back('{64'h0041_0042_0043_0044, 3'd4});
        for (int i = 0; i < 4; i++) send(16'h0041 + 16'(i), 0);

        // Reset mid-word with a held output word
        cycle();
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) send(16'h0051 + 16'(i), 0);
        @(negedge clk);
        chk("pre_rst_out_valid", 64'(out_valid), 64'd1);
        chk("pre_rst_acc_count", 64'(acc_count), 64'd2);
        cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_acc_count", 64'(acc_count), 64'd0);
        chk("mid_rst_out_data", out_data, 64'd0);
        chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;

        for (int w = 0; w < 20 && q.size() != 0; w++) cycle();
        chk("scoreboard_drained", 64'(q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
